// File: rtl/pulse_receiver.sv
// Deserializing receiver for a repeating WIDTH-bit pulse pattern: detects the
// pattern, aligns to its period, declares lock and flags aligned mismatches.
module pulse_receiver #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned LOCK_COUNT = 2,
   parameter int unsigned MISS_LIMIT = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             serial_in,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic             load_flag,
   output logic [WIDTH-1:0] word_out,
   output logic             match_pulse,
   output logic             error_pulse,
   output logic             locked,
   output logic [15:0]      match_count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = $clog2(WIDTH);
   localparam int unsigned KW = 4;
   localparam int unsigned MW = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      ALIGN  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] pattern_q;
   logic [CW-1:0]    bit_count_q;
   logic [PW-1:0]    phase_q;
   logic [KW-1:0]    hit_cnt_q;
   logic [KW-1:0]    miss_cnt_q;
   logic [MW-1:0]    match_count_q;
   logic             match_pulse_q;
   logic             error_pulse_q;
   logic             locked_q;

   logic             window_match_c;
   logic             checkpoint_c;
   logic [MW-1:0]    count_inc_c;
   logic [KW-1:0]    hit_next_c;
   logic [KW-1:0]    miss_next_c;

   assign window_match_c = (state_q != IDLE) && (bit_count_q == CW'(WIDTH)) &&
                           (shreg_q == pattern_q);
   assign checkpoint_c   = (phase_q == PW'(WIDTH - 1));
   // Saturating increment: match_count must never wrap.
   assign count_inc_c    = (match_count_q == {MW{1'b1}}) ? match_count_q
                                                         : match_count_q + MW'(1);
   assign hit_next_c     = hit_cnt_q + KW'(1);
   assign miss_next_c    = miss_cnt_q + KW'(1);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         shreg_q       <= '0;
         pattern_q     <= '0;
         bit_count_q   <= '0;
         phase_q       <= '0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
         match_count_q <= '0;
         match_pulse_q <= 1'b0;
         error_pulse_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         shreg_q       <= {shreg_q[WIDTH-2:0], serial_in};
         match_pulse_q <= 1'b0;
         error_pulse_q <= 1'b0;
         if (load_flag) begin
            pattern_q     <= pattern_in;
            bit_count_q   <= '0;
            phase_q       <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            match_count_q <= '0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
         end else begin
            if (bit_count_q != CW'(WIDTH)) bit_count_q <= bit_count_q + CW'(1);
            phase_q <= phase_q + PW'(1);
            unique case (state_q)
               IDLE: ;
               SEARCH: begin
                  if (window_match_c) begin
                     match_pulse_q <= 1'b1;
                     match_count_q <= count_inc_c;
                     phase_q       <= '0;
                     hit_cnt_q     <= KW'(1);
                     miss_cnt_q    <= '0;
                     if (LOCK_COUNT == 1) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end else begin
                        state_q  <= ALIGN;
                     end
                  end
               end
               ALIGN: begin
                  if (checkpoint_c) begin
                     if (window_match_c) begin
                        match_pulse_q <= 1'b1;
                        match_count_q <= count_inc_c;
                        phase_q       <= '0;
                        hit_cnt_q     <= hit_next_c;
                        if (hit_next_c == KW'(LOCK_COUNT)) begin
                           state_q  <= LOCKED;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        hit_cnt_q <= '0;
                        state_q   <= SEARCH;
                     end
                  end
               end
               LOCKED: begin
                  if (checkpoint_c) begin
                     phase_q <= '0;
                     if (window_match_c) begin
                        match_pulse_q <= 1'b1;
                        match_count_q <= count_inc_c;
                        miss_cnt_q    <= '0;
                     end else begin
                        error_pulse_q <= 1'b1;
                        miss_cnt_q    <= miss_next_c;
                        if (miss_next_c == KW'(MISS_LIMIT)) begin
                           state_q    <= SEARCH;
                           locked_q   <= 1'b0;
                           hit_cnt_q  <= '0;
                           miss_cnt_q <= '0;
                        end
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign word_out    = shreg_q;
   assign match_pulse = match_pulse_q;
   assign error_pulse = error_pulse_q;
   assign locked      = locked_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// Scoreboard bench for pulse_receiver: stimulus queues expected pulse events,
// a negedge monitor pops and checks them whenever the DUT emits a pulse.
module tb_pulse_receiver;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        serial_in;
   logic [15:0] pattern_in;
   logic        load_flag;
   logic [15:0] word_out;
   logic        match_pulse;
   logic        error_pulse;
   logic        locked;
   logic [15:0] match_count;

   pulse_receiver #(.WIDTH(16), .LOCK_COUNT(2), .MISS_LIMIT(1)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .serial_in   (serial_in),
      .pattern_in  (pattern_in),
      .load_flag   (load_flag),
      .word_out    (word_out),
      .match_pulse (match_pulse),
      .error_pulse (error_pulse),
      .locked      (locked),
      .match_count (match_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned at_edge;
      bit          is_err;
      bit          lk;
      int unsigned cnt;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         mon_e;
   int unsigned edge_n = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, edge_n, act, expv);
      end
   endtask

   task automatic push(input int unsigned e, input bit err, input bit lk, input int unsigned cnt);
      ev_t ev;
      ev.at_edge = e;
      ev.is_err  = err;
      ev.lk      = lk;
      ev.cnt     = cnt;
      exp_q.push_back(ev);
   endtask

   task automatic step(input logic b);
      serial_in = b;
      @(posedge clock);
      edge_n++;
      #1;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) step(w[i]);
   endtask

   task automatic do_load(input logic [15:0] p);
      load_flag  = 1'b1;
      pattern_in = p;
      step(1'b0);
      load_flag  = 1'b0;
   endtask

   // Monitor: every emitted pulse must be the next queued event.
   always @(negedge clock) begin
      if (match_pulse === 1'b1 || error_pulse === 1'b1) begin
         if (exp_q.size() == 0) begin
            cmp("unexpected_pulse", {30'd0, match_pulse, error_pulse}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            cmp("ev_edge", edge_n, mon_e.at_edge);
            cmp("ev_kind", {30'd0, match_pulse, error_pulse},
                {30'd0, ~mon_e.is_err, mon_e.is_err});
            cmp("ev_locked", {31'd0, locked}, {31'd0, mon_e.lk});
            cmp("ev_count", {16'd0, match_count}, mon_e.cnt);
         end
      end
   end

   int unsigned base;

   initial begin
      reset_n    = 1'b0;
      load_flag  = 1'b0;
      pattern_in = 16'h0000;
      serial_in  = 1'b0;

      // Reset, then idle with no pattern loaded
      repeat (3) step(1'b0);
      cmp("rst_word", {16'd0, word_out}, 32'h0);
      cmp("rst_match", {31'd0, match_pulse}, 32'd0);
      cmp("rst_error", {31'd0, error_pulse}, 32'd0);
      cmp("rst_locked", {31'd0, locked}, 32'd0);
      cmp("rst_count", {16'd0, match_count}, 32'd0);
      reset_n = 1'b1;
      repeat (40) step(1'b1);
      cmp("idle_locked", {31'd0, locked}, 32'd0);
      cmp("idle_count", {16'd0, match_count}, 32'd0);
      cmp("idle_word", {16'd0, word_out}, 32'hFFFF);

      // Clean acquisition, loss of lock, relock
      do_load(16'hB5C3);
      base = edge_n;
      push(base + 17, 0, 0, 1);
      push(base + 33, 0, 1, 2);
      push(base + 49, 0, 1, 3);
      push(base + 65, 0, 1, 4);
      push(base + 81, 1, 0, 4);
      push(base + 97, 0, 0, 5);
      push(base + 113, 0, 1, 6);
      for (int k = 0; k < 4; k++) begin
         send_word(16'hB5C3);
         cmp("acq_window", {16'd0, word_out}, 32'hB5C3);
      end
      send_word(16'hB5C3 ^ 16'h0001);
      repeat (3) send_word(16'hB5C3);
      cmp("relock_locked", {31'd0, locked}, 32'd1);

      // Reload while locked preempts the pending checkpoint
      do_load(16'h0F0F);
      base = edge_n;
      cmp("reload_locked", {31'd0, locked}, 32'd0);
      cmp("reload_count", {16'd0, match_count}, 32'd0);
      cmp("reload_pulse", {31'd0, match_pulse}, 32'd0);
      push(base + 17, 0, 0, 1);
      push(base + 33, 0, 1, 2);
      repeat (3) send_word(16'h0F0F);

      // Failed alignment: corrupted second period returns to SEARCH silently
      do_load(16'hB5C3);
      base = edge_n;
      push(base + 17, 0, 0, 1);
      push(base + 49, 0, 0, 2);
      push(base + 65, 0, 1, 3);
      push(base + 81, 0, 1, 4);
      send_word(16'hB5C3);
      send_word(16'hB5C3 ^ 16'h0001);
      send_word(16'hB5C3);
      cmp("align_fail_locked", {31'd0, locked}, 32'd0);
      repeat (3) send_word(16'hB5C3);

      // Periodic pattern: only period-aligned matches after first detection
      do_load(16'hAAAA);
      base = edge_n;
      push(base + 17, 0, 0, 1);
      push(base + 33, 0, 1, 2);
      push(base + 49, 0, 1, 3);
      repeat (4) send_word(16'hAAAA);
      cmp("periodic_locked", {31'd0, locked}, 32'd1);
      cmp("periodic_count", {16'd0, match_count}, 32'd3);

      // Reset mid-lock clears everything on that edge
      reset_n = 1'b0;
      step(1'b1);
      cmp("midrst_word", {16'd0, word_out}, 32'h0);
      cmp("midrst_match", {31'd0, match_pulse}, 32'd0);
      cmp("midrst_error", {31'd0, error_pulse}, 32'd0);
      cmp("midrst_locked", {31'd0, locked}, 32'd0);
      cmp("midrst_count", {16'd0, match_count}, 32'd0);
      reset_n = 1'b1;
      repeat (20) step(1'b0);
      cmp("post_rst_count", {16'd0, match_count}, 32'd0);

      cmp("pending_events", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
